// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the serial receive/transmit blocks.
//   parity_e   : frame parity mode (none / even / odd)
//   rx_state_e : receiver sequencing states
//   parityMismatch() : parity check for a completed data word
package uart_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 260;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_DELIVER   = 3'd5,
        RX_WAIT_HIGH = 3'd6
    } rx_state_e;

    // dataXor is the XOR of all received data bits. Even parity expects
    // dataXor ^ sample == 0, odd parity expects it to be 1.
    function automatic logic parityMismatch(input logic dataXor, input logic sample,
                                            input parity_e mode);
        return (dataXor ^ sample) != (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Bit-period timer for UART sequencing. Counts clk cycles from 0 and raises
//   sampleTick for one cycle at the sample point, then wraps to 0 so a state
//   that spans several bits keeps ticking once per bit period.
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   clear      in   hold the counter at 0 (no tick while asserted)
//   halfSel    in   1: tick at CLKS_PER_BIT/2-1, 0: tick at CLKS_PER_BIT-1
//   sampleTick out  one-cycle sample strobe
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 260
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic halfSel,
    output logic sampleTick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] target;

    assign target     = halfSel ? HALF_LAST : FULL_LAST;
    assign sampleTick = !clear && (count == target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || sampleTick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed
//   Framed UART receiver: 2-flop input synchroniser, start-bit glitch
//   rejection, configurable data/parity/stop format, parity/framing/break
//   status and a valid/ready output handshake with overrun reporting.
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   uart_rx       in   serial line, idle high, asynchronous to clk
//   rx_data       out  received word, bit 0 = first bit on the line
//   rx_valid      out  word available, held until accepted
//   rx_ready      in   consumer accepts when rx_valid & rx_ready
//   rx_parity_err out  parity mismatch for rx_data (qualified by rx_valid)
//   rx_frame_err  out  a stop bit sampled low (qualified by rx_valid)
//   rx_break      out  every data/parity/stop sample low (qualified by rx_valid)
//   rx_overrun    out  one-cycle pulse: completed frame dropped, old word held
//   rx_busy       out  receiver not idle
//
// state        | meaning
// RX_IDLE      | line idle, waiting for falling edge on synchronised line
// RX_START     | half-bit wait, re-check start bit to reject glitches
// RX_DATA      | sample DATA_BITS data bits, LSB first
// RX_PARITY    | sample parity bit and compare against data
// RX_STOP      | sample STOP_BITS stop bits, low sample flags framing error
// RX_DELIVER   | one cycle: hand the word to the output registers
// RX_WAIT_HIGH | line still low after frame (break), wait for it to rise
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
        $error("uart_rx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : gBadParity
        $error("uart_rx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
        $error("uart_rx_framed: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 8) begin : gBadClksPerBit
        $error("uart_rx_framed: CLKS_PER_BIT must be >= 8");
    end

    localparam int            IW        = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);
    localparam logic          PAR_ON    = (PARITY != 0);
    localparam parity_e       PAR_MODE  = (PARITY == 2) ? PAR_ODD :
                                          ((PARITY == 1) ? PAR_EVEN : PAR_NONE);

    rx_state_e            state;
    logic                 rxSync1;
    logic                 rxS;
    logic [IW-1:0]        bitIdx;
    logic                 stopIdx;
    logic [DATA_BITS-1:0] shiftData;
    logic                 parErr;
    logic                 frameErr;
    logic                 allLow;
    logic                 sampleTick;
    logic                 timerClear;

    // Every transition out of a timed state happens on a tick, which already
    // wraps the counter; the untimed states hold it cleared so the count is 0
    // on entry to every state.
    assign timerClear = (state == RX_IDLE) || (state == RX_DELIVER) ||
                        (state == RX_WAIT_HIGH);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uBitTimer (
        .clk       (clk),
        .reset     (reset),
        .clear     (timerClear),
        .halfSel   (state == RX_START),
        .sampleTick(sampleTick)
    );

    assign rx_busy = (state != RX_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxSync1       <= 1'b1;
            rxS           <= 1'b1;
            state         <= RX_IDLE;
            bitIdx        <= '0;
            stopIdx       <= 1'b0;
            shiftData     <= '0;
            parErr        <= 1'b0;
            frameErr      <= 1'b0;
            allLow        <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rxSync1    <= uart_rx;
            rxS        <= rxSync1;
            rx_overrun <= 1'b0;

            // Plain acceptance; a delivery in the same cycle is handled below
            // and keeps rx_valid high with the new word.
            if (state != RX_DELIVER && rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    if (!rxS) begin
                        state <= RX_START;
                    end
                end

                RX_START: begin
                    if (sampleTick) begin
                        if (rxS) begin
                            state <= RX_IDLE;
                        end else begin
                            state    <= RX_DATA;
                            bitIdx   <= '0;
                            stopIdx  <= 1'b0;
                            parErr   <= 1'b0;
                            frameErr <= 1'b0;
                            allLow   <= 1'b1;
                        end
                    end
                end

                RX_DATA: begin
                    if (sampleTick) begin
                        shiftData[bitIdx] <= rxS;
                        if (rxS) begin
                            allLow <= 1'b0;
                        end
                        if (bitIdx == LAST_BIT) begin
                            state <= PAR_ON ? RX_PARITY : RX_STOP;
                        end else begin
                            bitIdx <= bitIdx + IW'(1);
                        end
                    end
                end

                RX_PARITY: begin
                    if (sampleTick) begin
                        parErr <= parityMismatch(^shiftData, rxS, PAR_MODE);
                        if (rxS) begin
                            allLow <= 1'b0;
                        end
                        state <= RX_STOP;
                    end
                end

                RX_STOP: begin
                    if (sampleTick) begin
                        if (!rxS) begin
                            frameErr <= 1'b1;
                        end else begin
                            allLow <= 1'b0;
                        end
                        if (stopIdx == LAST_STOP) begin
                            state <= RX_DELIVER;
                        end else begin
                            stopIdx <= stopIdx + 1'b1;
                        end
                    end
                end

                RX_DELIVER: begin
                    if (!rx_valid || rx_ready) begin
                        rx_data       <= shiftData;
                        rx_parity_err <= parErr;
                        rx_frame_err  <= frameErr;
                        rx_break      <= allLow;
                        rx_valid      <= 1'b1;
                    end else begin
                        rx_overrun <= 1'b1;
                    end
                    // A line still low here is a break or a held-low line;
                    // do not mistake it for the next start bit.
                    state <= rxS ? RX_IDLE : RX_WAIT_HIGH;
                end

                RX_WAIT_HIGH: begin
                    if (rxS) begin
                        state <= RX_IDLE;
                    end
                end

                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
module tb_uart_rx_framed;

    localparam int N    = 16;
    localparam int HALF = N / 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic lineA = 1'b1, lineB = 1'b1, lineC = 1'b1;
    logic readyA = 1'b0;
    logic readyBC = 1'b1;

    logic [7:0] dataA;
    logic validA, perrA, ferrA, brkA, ovrA, busyA;
    logic [6:0] dataB;
    logic validB, perrB, ferrB, brkB, ovrB, busyB;
    logic [7:0] dataC;
    logic validC, perrC, ferrC, brkC, ovrC, busyC;

    always #5 clk = ~clk;

    // 8N1
    uart_rx_framed #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
        .clk(clk), .reset(reset), .uart_rx(lineA), .rx_data(dataA), .rx_valid(validA),
        .rx_ready(readyA), .rx_parity_err(perrA), .rx_frame_err(ferrA), .rx_break(brkA),
        .rx_overrun(ovrA), .rx_busy(busyA));
    // 7E1
    uart_rx_framed #(.CLKS_PER_BIT(N), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dutB (
        .clk(clk), .reset(reset), .uart_rx(lineB), .rx_data(dataB), .rx_valid(validB),
        .rx_ready(readyBC), .rx_parity_err(perrB), .rx_frame_err(ferrB), .rx_break(brkB),
        .rx_overrun(ovrB), .rx_busy(busyB));
    // 8O2
    uart_rx_framed #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dutC (
        .clk(clk), .reset(reset), .uart_rx(lineC), .rx_data(dataC), .rx_valid(validC),
        .rx_ready(readyBC), .rx_parity_err(perrC), .rx_frame_err(ferrC), .rx_break(brkC),
        .rx_overrun(ovrC), .rx_busy(busyC));

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model for dutA ----------------
    typedef struct {
        int         loadCyc;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } cap_t;

    exp_t expQ[$];
    exp_t curE;
    cap_t capB[$], capC[$];
    cap_t capE;

    int         cyc = 0;
    int         lastLoad = 0;
    logic       mValid = 0, mPerr = 0, mFerr = 0, mBrk = 0, mOvr = 0;
    logic [8:0] mData = 0;

    int         validCycles = 0;
    int         ovrCount = 0;
    logic       validLowSeen = 0;
    logic [7:0] lastData = 0;
    logic       lastPerr = 0, lastFerr = 0, lastBrk = 0;

    task automatic modelClear();
        mValid = 0; mData = 0; mPerr = 0; mFerr = 0; mBrk = 0; mOvr = 0;
        expQ.delete();
    endtask

    // The word completed by a frame is offered to the consumer at a known
    // cycle; a held unaccepted word makes the new one an overrun.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            modelClear();
        end else begin
            mOvr = 0;
            if (expQ.size() > 0 && expQ[0].loadCyc == cyc) begin
                curE = expQ.pop_front();
                if (!mValid || readyA) begin
                    mValid = 1; mData = curE.data;
                    mPerr = curE.perr; mFerr = curE.ferr; mBrk = curE.brk;
                end else begin
                    mOvr = 1;
                end
            end else if (mValid && readyA) begin
                mValid = 0;
            end
        end
    end

    // Compare process plus observation counters.
    initial forever begin
        @(negedge clk);
        check("valid", validA, mValid);
        check("overrun", ovrA, mOvr);
        if (mValid) begin
            check("data", dataA, mData);
            check("parity_err", perrA, mPerr);
            check("frame_err", ferrA, mFerr);
            check("break", brkA, mBrk);
        end
        if (validA) begin
            validCycles++;
            lastData = dataA; lastPerr = perrA; lastFerr = ferrA; lastBrk = brkA;
        end else begin
            validLowSeen = 1;
        end
        if (ovrA) ovrCount++;
        if (validB) capB.push_back('{data: {2'b0, dataB}, perr: perrB, ferr: ferrB, brk: brkB});
        if (validC) capC.push_back('{data: {1'b0, dataC}, perr: perrC, ferr: ferrC, brk: brkC});
    end

    // ---------------- stimulus helpers ----------------
    task automatic buildFrame(input logic [8:0] data, input int nData, input int parMode,
                              input logic flipPar, input int nStop, input logic stopLow,
                              output logic [63:0] bits, output int n, output logic [8:0] dOut,
                              output logic perr, output logic ferr, output logic brk);
        logic p;
        int   ones;
        bits = '1;
        n = 0;
        ones = 0;
        dOut = '0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nData; i++) begin
            bits[n] = data[i]; n++;
            dOut[i] = data[i];
            if (data[i]) ones++;
        end
        // even: parity bit makes the total count of ones even; odd: odd
        p = 1'b0;
        if (parMode == 1) p = (ones % 2 == 1);
        if (parMode == 2) p = (ones % 2 == 0);
        p = p ^ flipPar;
        if (parMode != 0) begin
            bits[n] = p; n++;
        end
        for (int s = 0; s < nStop; s++) begin
            bits[n] = !stopLow; n++;
        end
        perr = (parMode != 0) && flipPar;
        ferr = stopLow;
        brk  = (ones == 0) && (parMode == 0 || p == 1'b0) && stopLow;
    endtask

    task automatic setLine(input int which, input logic v);
        case (which)
            0: lineA = v;
            1: lineB = v;
            default: lineC = v;
        endcase
    endtask

    task automatic driveBits(input int which, input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            setLine(which, bits[i]);
            repeat (N) @(posedge clk);
            #1;
        end
        setLine(which, 1'b1);
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    // Line change lands just after edge c0; the last stop sample reaches the
    // FSM 2 sync cycles after its mid-bit point, and the outputs follow one
    // cycle after that.
    task automatic sendMain(input logic [7:0] data, input logic stopLow);
        logic [63:0] bits;
        int          n;
        logic [8:0]  d;
        logic        pe, fe, bk;
        exp_t        e;
        @(posedge clk);
        #1;
        buildFrame({1'b0, data}, 8, 0, 1'b0, 1, stopLow, bits, n, d, pe, fe, bk);
        e.loadCyc = cyc + 4 + HALF + (n - 1) * N;
        e.data = d; e.perr = pe; e.ferr = fe; e.brk = bk;
        lastLoad = e.loadCyc;
        expQ.push_back(e);
        driveBits(0, bits, n);
    endtask

    task automatic sendOther(input int which, input logic [7:0] data, input int nData,
                             input int parMode, input logic flipPar, input int nStop,
                             input string name);
        logic [63:0] bits;
        int          n;
        logic [8:0]  d;
        logic        pe, fe, bk;
        @(posedge clk);
        #1;
        buildFrame({1'b0, data}, nData, parMode, flipPar, nStop, 1'b0, bits, n, d, pe, fe, bk);
        driveBits(which, bits, n);
        idle(N);
        if (which == 1) begin
            check({name, " count"}, capB.size(), 1);
            if (capB.size() > 0) capE = capB.pop_front();
            capB.delete();
        end else begin
            check({name, " count"}, capC.size(), 1);
            if (capC.size() > 0) capE = capC.pop_front();
            capC.delete();
        end
        check({name, " data"}, capE.data, d);
        check({name, " parity_err"}, capE.perr, pe);
        check({name, " frame_err"}, capE.ferr, 1'b0);
        check({name, " break"}, capE.brk, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] pbits;
        int          pn, vc;
        logic [8:0]  pd;
        logic        ppe, pfe, pbk;

        // model pins: hand-assembled line images
        buildFrame(9'h055, 7, 1, 1'b0, 1, 1'b0, pbits, pn, pd, ppe, pfe, pbk);
        check("pin 7E1 0x55 image", {22'd0, pbits[9:0]}, 32'h2AA);
        check("pin 7E1 0x55 length", pn, 10);
        buildFrame(9'h03A, 8, 2, 1'b0, 2, 1'b0, pbits, pn, pd, ppe, pfe, pbk);
        check("pin 8O2 0x3A image", {20'd0, pbits[11:0]}, 32'hE74);
        buildFrame(9'h000, 8, 0, 1'b0, 1, 1'b1, pbits, pn, pd, ppe, pfe, pbk);
        check("pin break flags", {29'd0, ppe, pfe, pbk}, 32'b011);

        // reset state
        idle(2);
        check("reset valid", validA, 1'b0);
        check("reset data", dataA, 8'h00);
        check("reset busy", busyA, 1'b0);
        check("reset overrun", ovrA, 1'b0);
        @(posedge clk); #2;
        reset = 1'b0;
        idle(4);

        // 1: 8N1 0x4C, consumer always ready
        readyA = 1'b1;
        vc = validCycles;
        sendMain(8'h4C, 1'b0);
        check("t1 valid cycles", validCycles - vc, 1);
        check("t1 data", lastData, 8'h4C);
        check("t1 status", {lastPerr, lastFerr, lastBrk}, 3'b000);
        check("t1 busy after", busyA, 1'b0);
        idle(N);

        // 2: parity formats, correct then flipped parity
        sendOther(1, 8'h55, 7, 1, 1'b0, 1, "7E1 0x55 good");
        sendOther(1, 8'h55, 7, 1, 1'b1, 1, "7E1 0x55 bad");
        sendOther(1, 8'h3A, 7, 1, 1'b0, 1, "7E1 0x3A good");
        sendOther(1, 8'h3A, 7, 1, 1'b1, 1, "7E1 0x3A bad");
        sendOther(2, 8'h55, 8, 2, 1'b0, 2, "8O2 0x55 good");
        sendOther(2, 8'h55, 8, 2, 1'b1, 2, "8O2 0x55 bad");
        sendOther(2, 8'h3A, 8, 2, 1'b0, 2, "8O2 0x3A good");
        sendOther(2, 8'h3A, 8, 2, 1'b1, 2, "8O2 0x3A bad");

        // 3: framing error, break, recovery
        sendMain(8'hA5, 1'b1);
        idle(N);
        check("t3 fe data", lastData, 8'hA5);
        check("t3 fe status", {lastPerr, lastFerr, lastBrk}, 3'b010);

        vc = validCycles;
        @(posedge clk); #1;
        curE.loadCyc = cyc + 4 + HALF + 9 * N;
        curE.data = '0; curE.perr = 1'b0; curE.ferr = 1'b1; curE.brk = 1'b1;
        expQ.push_back(curE);
        lineA = 1'b0;
        idle(20 * N);
        check("t3 busy in break", busyA, 1'b1);
        idle(10 * N);
        lineA = 1'b1;
        idle(2);
        check("t3 still waiting", busyA, 1'b1);
        idle(2);
        check("t3 idle after break", busyA, 1'b0);
        check("t3 break valid cycles", validCycles - vc, 1);
        check("t3 break data", lastData, 8'h00);
        check("t3 break status", {lastPerr, lastFerr, lastBrk}, 3'b011);
        idle(N);
        sendMain(8'h12, 1'b0);
        check("t3 recover data", lastData, 8'h12);
        check("t3 recover status", {lastPerr, lastFerr, lastBrk}, 3'b000);
        idle(N);

        // 4: 5-cycle low glitch on idle line
        vc = validCycles;
        lineA = 1'b0;
        idle(5);
        lineA = 1'b1;
        check("t4 busy during glitch", busyA, 1'b1);
        idle(HALF + 3 - 5);
        check("t4 busy cleared", busyA, 1'b0);
        idle(2 * N);
        check("t4 no valid", validCycles - vc, 0);

        // 5: overrun, then acceptance exactly in DELIVER
        readyA = 1'b0;
        ovrCount = 0;
        sendMain(8'h11, 1'b0);
        idle(N);
        sendMain(8'h22, 1'b0);
        idle(N);
        check("t5 held data", dataA, 8'h11);
        check("t5 overrun pulses", ovrCount, 1);
        validLowSeen = 1'b0;
        fork
            sendMain(8'h33, 1'b0);
            begin
                @(posedge clk); #2;
                while (cyc < lastLoad - 1) begin
                    @(posedge clk); #1;
                end
                readyA = 1'b1;
                @(posedge clk); #1;
                readyA = 1'b0;
            end
        join
        idle(4);
        check("t5 new data", dataA, 8'h33);
        check("t5 no extra overrun", ovrCount, 1);
        check("t5 valid continuous", validLowSeen, 1'b0);
        readyA = 1'b1;
        idle(2);
        check("t5 accepted", validA, 1'b0);
        readyA = 1'b0;

        // 6: reset mid-DATA with a word held, then clean frame
        sendMain(8'h5A, 1'b0);
        idle(N);
        fork
            sendMain(8'hFF, 1'b0);
            begin
                @(posedge clk);
                repeat (5 * N) @(posedge clk);
                #2;
                reset = 1'b1;
                modelClear();
                #1;
                check("t6 valid", validA, 1'b0);
                check("t6 data", dataA, 8'h00);
                check("t6 status", {perrA, ferrA, brkA, ovrA}, 4'b0000);
                check("t6 busy", busyA, 1'b0);
            end
        join
        @(posedge clk); #2;
        reset = 1'b0;
        idle(4);
        readyA = 1'b1;
        vc = validCycles;
        sendMain(8'h81, 1'b0);
        idle(N);
        check("t6 valid cycles", validCycles - vc, 1);
        check("t6 data after", lastData, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
